// File: rtl/cla_seq_addsub.sv
// Multi-cycle carry-lookahead adder/subtractor: resolves one BLOCK-bit lookahead
// slice per cycle, rippling the carry between slices through a register.
module cla_seq_addsub #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_A,
    input  logic [WIDTH-1:0] data_B,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             busy
);

    localparam int NBLK  = WIDTH / BLOCK;
    localparam int IDX_W = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBLK - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry_q;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    int               shamt;
    logic [BLOCK-1:0] slice_a;
    logic [BLOCK-1:0] slice_b;
    logic [BLOCK-1:0] gen;
    logic [BLOCK-1:0] prop;
    logic [BLOCK-1:0] slice_sum;
    logic [BLOCK:0]   carry_vec;
    logic             term;
    logic             carry_acc;
    logic [WIDTH-1:0] slice_mask;
    logic [WIDTH-1:0] next_result;

    // Each carry is an explicit sum of products of g/p terms and the incoming
    // carry, so no carry depends on a neighbouring bit's carry inside the slice.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        shamt     = int'(idx) * BLOCK;
        slice_a   = BLOCK'(op_a >> shamt);
        slice_b   = BLOCK'(op_b >> shamt);
        gen       = slice_a & slice_b;
        prop      = slice_a | slice_b;
        carry_vec = '0;
        term      = 1'b0;
        carry_acc = 1'b0;
        carry_vec[0] = carry_q;
        for (int i = 0; i < BLOCK; i++) begin
            term = carry_q;
            for (int k = 0; k <= i; k++) begin
                term = term & prop[k];
            end
            carry_acc = term;
            for (int j = 0; j <= i; j++) begin
                term = gen[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & prop[k];
                end
                carry_acc = carry_acc | term;
            end
            carry_vec[i+1] = carry_acc;
        end
        slice_sum   = slice_a ^ slice_b ^ carry_vec[BLOCK-1:0];
        slice_mask  = WIDTH'({BLOCK{1'b1}}) << shamt;
        next_result = (result & ~slice_mask) | (WIDTH'(slice_sum) << shamt);
    end

    // NOTE: the operand registers carry no reset; they are always loaded before use.
    always_ff @(posedge clock) begin
        if (in_ready && in_valid) begin
            op_a <= data_A;
            op_b <= sub ? ~data_B : data_B;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry_q   <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        carry_q  <= sub;
                        idx      <= '0;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    result  <= next_result;
                    carry_q <= carry_vec[BLOCK];
                    idx     <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        // Signed overflow compares carries into and out of the MSB.
                        carry_out <= carry_vec[BLOCK];
                        overflow  <= carry_vec[BLOCK-1] ^ carry_vec[BLOCK];
                        zero      <= (next_result == '0);
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_seq_addsub.sv
// Randomised and directed checks of cla_seq_addsub against an arithmetic model,
// for the default configuration plus 16/4 and 32/16 parameter points.
module tb_cla_seq_addsub;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic [2:0]  in_valid_v  = '0;
    logic [2:0]  out_ready_v = '0;
    logic [2:0]  sub_v       = '0;
    logic [31:0] a_v [3];
    logic [31:0] b_v [3];

    wire [2:0]  in_ready_v;
    wire [2:0]  out_valid_v;
    wire [2:0]  busy_v;
    wire [2:0]  cout_v;
    wire [2:0]  ovf_v;
    wire [2:0]  zero_v;
    wire [31:0] res0;
    wire [15:0] res1;
    wire [31:0] res2;

    int n_checks = 0;
    int n_fail   = 0;

    cla_seq_addsub #(.WIDTH(32), .BLOCK(8)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .data_A(a_v[0]), .data_B(b_v[0]), .sub(sub_v[0]), .out_valid(out_valid_v[0]),
        .out_ready(out_ready_v[0]), .result(res0), .carry_out(cout_v[0]), .overflow(ovf_v[0]),
        .zero(zero_v[0]), .busy(busy_v[0])
    );

    cla_seq_addsub #(.WIDTH(16), .BLOCK(4)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .data_A(a_v[1][15:0]), .data_B(b_v[1][15:0]), .sub(sub_v[1]), .out_valid(out_valid_v[1]),
        .out_ready(out_ready_v[1]), .result(res1), .carry_out(cout_v[1]), .overflow(ovf_v[1]),
        .zero(zero_v[1]), .busy(busy_v[1])
    );

    cla_seq_addsub #(.WIDTH(32), .BLOCK(16)) u_dut2 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .data_A(a_v[2]), .data_B(b_v[2]), .sub(sub_v[2]), .out_valid(out_valid_v[2]),
        .out_ready(out_ready_v[2]), .result(res2), .carry_out(cout_v[2]), .overflow(ovf_v[2]),
        .zero(zero_v[2]), .busy(busy_v[2])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int width_of(input int u);
        return (u == 1) ? 16 : 32;
    endfunction

    function automatic int nblk_of(input int u);
        return (u == 2) ? 2 : 4;
    endfunction

    function automatic logic [31:0] get_res(input int u);
        case (u)
            0:       return res0;
            1:       return {16'h0000, res1};
            default: return res2;
        endcase
    endfunction

    // Reference: unsigned range for carry/borrow, signed range for overflow.
    task automatic model(input int w, input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] r, output logic c, output logic v, output logic z);
        longint full_range = longint'(1) << w;
        longint half = full_range / 2;
        longint ua = longint'(a) & (full_range - 1);
        longint ub = longint'(b) & (full_range - 1);
        longint sa = (ua >= half) ? ua - full_range : ua;
        longint sb = (ub >= half) ? ub - full_range : ub;
        longint ures = s ? ua - ub : ua + ub;
        longint sres = s ? sa - sb : sa + sb;
        c = s ? (ua >= ub) : (ures >= full_range);
        v = (sres >= half) || (sres < -half);
        r = 32'((ures + full_range) & (full_range - 1));
        z = (r == 32'd0);
    endtask

    function automatic logic [31:0] rand_op(input int w);
        logic [31:0] mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        logic [31:0] smin = 32'd1 << (w - 1);
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return mask;
            3:       return smin;
            4:       return smin - 32'd1;
            default: return $urandom & mask;
        endcase
    endfunction

    // Entered and left on a falling edge; hold = DONE cycles with out_ready low.
    task automatic run_op(input int u, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int hold);
        int w = width_of(u);
        int nb = nblk_of(u);
        int wait_cnt = 0;
        int lat = 0;
        logic [31:0] exp_r;
        logic exp_c, exp_v, exp_z;
        string tag;
        tag = $sformatf("u%0d %h%s%h", u, a, s ? "-" : "+", b);
        while (!in_ready_v[u] && wait_cnt < 50) begin
            @(negedge clock);
            wait_cnt++;
        end
        check({tag, " in_ready"}, 64'(in_ready_v[u]), 64'd1);
        if (!in_ready_v[u]) return;
        a_v[u] = a;
        b_v[u] = b;
        sub_v[u] = s;
        in_valid_v[u] = 1'b1;
        @(negedge clock);
        in_valid_v[u] = 1'b0;
        a_v[u] = $urandom;
        b_v[u] = $urandom;
        sub_v[u] = 1'($urandom_range(0, 1));
        check({tag, " busy"}, 64'(busy_v[u]), 64'd1);
        while (!out_valid_v[u] && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(nb));
        model(w, a, b, s, exp_r, exp_c, exp_v, exp_z);
        check({tag, " result"}, 64'(get_res(u)), 64'(exp_r));
        check({tag, " carry_out"}, 64'(cout_v[u]), 64'(exp_c));
        check({tag, " overflow"}, 64'(ovf_v[u]), 64'(exp_v));
        check({tag, " zero"}, 64'(zero_v[u]), 64'(exp_z));
        check({tag, " in_ready_done"}, 64'(in_ready_v[u]), 64'd0);
        for (int h = 0; h < hold; h++) begin
            in_valid_v[u] = 1'($urandom_range(0, 1));
            a_v[u] = $urandom;
            b_v[u] = $urandom;
            @(negedge clock);
            check({tag, " hold_result"}, 64'(get_res(u)), 64'(exp_r));
            check({tag, " hold_flags"}, 64'({cout_v[u], ovf_v[u], zero_v[u]}),
                  64'({exp_c, exp_v, exp_z}));
            check({tag, " hold_valid"}, 64'({out_valid_v[u], in_ready_v[u]}), 64'b10);
        end
        in_valid_v[u] = 1'b0;
        out_ready_v[u] = 1'b1;
        @(negedge clock);
        out_ready_v[u] = 1'b0;
        check({tag, " release"}, 64'({out_valid_v[u], in_ready_v[u]}), 64'b01);
    endtask

    task automatic check_reset_state(input int u, input string tag);
        check($sformatf("%s u%0d in_ready", tag, u), 64'(in_ready_v[u]), 64'd1);
        check($sformatf("%s u%0d outs", tag, u),
              64'({out_valid_v[u], busy_v[u], cout_v[u], ovf_v[u], zero_v[u]}), 64'd0);
        check($sformatf("%s u%0d result", tag, u), 64'(get_res(u)), 64'd0);
    endtask

    initial begin
        int seen;
        for (int u = 0; u < 3; u++) begin
            a_v[u] = '0;
            b_v[u] = '0;
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int u = 0; u < 3; u++) check_reset_state(u, "reset");
        reset_n = 1'b1;
        @(negedge clock);

        // Directed cases on the default configuration.
        run_op(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 5);
        run_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
        run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
        run_op(0, 32'h0000_0005, 32'h0000_0005, 1'b1, 0);
        run_op(0, 32'h8000_0000, 32'h0000_0001, 1'b1, 2);
        run_op(0, 32'h0000_0000, 32'h0000_0001, 1'b1, 0);

        // Reset during the second BUSY cycle abandons the operation.
        a_v[0] = 32'h1234_5678;
        b_v[0] = 32'h0FED_CBA9;
        sub_v[0] = 1'b0;
        in_valid_v[0] = 1'b1;
        @(negedge clock);
        in_valid_v[0] = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        check_reset_state(0, "midreset");
        seen = 0;
        repeat (6) begin
            @(negedge clock);
            seen = seen | int'(out_valid_v[0]);
        end
        check("midreset no_out_valid", 64'(seen), 64'd0);
        run_op(0, 32'd3, 32'd4, 1'b0, 0);

        // Parameter points.
        run_op(1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 0);
        run_op(1, 32'h0000_8000, 32'h0000_0001, 1'b1, 0);
        run_op(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
        run_op(2, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1);

        // Randomised operations with occasional backpressure.
        for (int n = 0; n < 60; n++) begin
            int u = n % 3;
            int w = width_of(u);
            run_op(u, rand_op(w), rand_op(w), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
